// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - b_in, one bit per clock, LSB first, start/busy/done handshake.
// Optional macro SERIAL_SUBTRACTOR_ADD_MODE_EN adds an 'add' port selecting d = a + b + b_in.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
   input  logic             add,
`endif
   output logic [WIDTH-1:0] d,
   output logic             b_out,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] r_sr_q, r_sr_d;
   logic             bor_q, bor_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
   logic             add_q, add_d;
`endif

   logic ai, bi, di, bor_nxt, ovf_bit;

   // Full-subtractor (or full-adder) cell on the current LSBs of the operand shifters
   assign ai = a_sr_q[0];
   assign bi = b_sr_q[0];
   assign di = ai ^ bi ^ bor_q;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
   assign bor_nxt = add_q ? ((ai & bi) | ((ai ^ bi) & bor_q))
                          : ((~ai & bi) | (~(ai ^ bi) & bor_q));
   assign ovf_bit = add_q ? (~(ai ^ bi) & (ai ^ di))
                          : ((ai ^ bi) & (ai ^ di));
`else
   assign bor_nxt = (~ai & bi) | (~(ai ^ bi) & bor_q);
   assign ovf_bit = (ai ^ bi) & (ai ^ di);
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      r_sr_d  = r_sr_q;
      bor_d   = bor_q;
      d_d     = d_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      add_d   = add_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_sr_d  = a;
               b_sr_d  = b;
               bor_d   = b_in;
               cnt_d   = '0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
               add_d   = add;
`endif
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            r_sr_d = {di, r_sr_q[WIDTH-1:1]};
            bor_d  = bor_nxt;
            cnt_d  = cnt_q + CW'(1);
            // On the MSB the cell sees the sign bits, so overflow comes straight from it
            if (cnt_q == CW'(WIDTH - 1)) begin
               d_d     = {di, r_sr_q[WIDTH-1:1]};
               bout_d  = bor_nxt;
               ovf_d   = ovf_bit;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         r_sr_q  <= '0;
         bor_q   <= 1'b0;
         d_q     <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
         add_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         r_sr_q  <= r_sr_d;
         bor_q   <= bor_d;
         d_q     <= d_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
         add_q   <= add_d;
`endif
      end
   end

   assign d        = d_q;
   assign b_out    = bout_q;
   assign overflow = ovf_q;
   assign busy     = (state_q == SHIFT);
   assign done     = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed and random ops against an arithmetic model.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_r = 1'b0;
   logic [7:0] a_r = '0, b_r = '0;
   logic       bin_r = 1'b0;
   logic       add_r = 1'b0;
   logic [7:0] d;
   logic       b_out, overflow, busy, done;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start_r), .a(a_r), .b(b_r), .b_in(bin_r),
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      .add(add_r),
`endif
      .d(d), .b_out(b_out), .overflow(overflow), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands
   task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin, input logic madd,
                        output logic [7:0] md, output logic mbo, output logic mov);
      logic [8:0] u;
      int s;
      if (madd) begin
         u = 9'(ma) + 9'(mb) + 9'(mbin);
         s = int'($signed(ma)) + int'($signed(mb)) + int'(mbin);
      end else begin
         u = 9'(ma) - 9'(mb) - 9'(mbin);
         s = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
      end
      md  = u[7:0];
      mbo = u[8];
      mov = (s < -128) || (s > 127);
   endtask

   // Drives start for one cycle, then scrambles the inputs; returns at the negedge after the accepting edge
   task automatic launch(input logic [7:0] la, input logic [7:0] lb, input logic lbin, input logic ladd);
      a_r = la; b_r = lb; bin_r = lbin; add_r = ladd; start_r = 1'b1;
      @(negedge clk);
      start_r = 1'b0;
      a_r = 8'($urandom); b_r = 8'($urandom); bin_r = 1'($urandom); add_r = 1'($urandom);
   endtask

   task automatic wait_done(input int lat0, output int lat, output int bcnt);
      lat = lat0;
      bcnt = (busy === 1'b1) ? 1 : 0;
      while (done !== 1'b1 && lat < 30) begin
         @(negedge clk);
         lat++;
         if (busy === 1'b1) bcnt++;
      end
   endtask

   task automatic check_res(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                            input logic ebin, input logic eadd);
      logic [7:0] md;
      logic mbo, mov;
      model(ea, eb, ebin, eadd, md, mbo, mov);
      chk({tag, ".d"}, 32'(d), 32'(md));
      chk({tag, ".b_out"}, 32'(b_out), 32'(mbo));
      chk({tag, ".ovf"}, 32'(overflow), 32'(mov));
   endtask

   task automatic run_op(input string tag, input logic [7:0] ra, input logic [7:0] rb,
                         input logic rbin, input logic radd);
      int lat, bc;
      logic [7:0] dh;
      launch(ra, rb, rbin, radd);
      wait_done(1, lat, bc);
      chk({tag, ".lat"}, 32'(lat), 32'd9);
      chk({tag, ".busy_cycles"}, 32'(bc), 32'd8);
      check_res(tag, ra, rb, rbin, radd);
      dh = d;
      @(negedge clk);
      chk({tag, ".done_pulse"}, 32'(done), 32'd0);
      chk({tag, ".d_hold"}, 32'(d), 32'(dh));
   endtask

   initial begin
      int lat, bc, dcount;
      logic [7:0] xa, xb;
      logic xbin;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst.d", 32'(d), 32'd0);
      chk("rst.b_out", 32'(b_out), 32'd0);
      chk("rst.ovf", 32'(overflow), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors
      run_op("t5A_23", 8'h5A, 8'h23, 1'b0, 1'b0);
      chk("t5A_23.lit", 32'(d), 32'h37);
      run_op("t00_01", 8'h00, 8'h01, 1'b0, 1'b0);
      chk("t00_01.lit", 32'({b_out, d}), 32'h1FF);
      run_op("t80_01", 8'h80, 8'h01, 1'b0, 1'b0);
      chk("t80_01.lit", 32'({overflow, d}), 32'h17F);
      run_op("t10_0F", 8'h10, 8'h0F, 1'b1, 1'b0);
      chk("t10_0F.lit", 32'({overflow, b_out, d}), 32'h000);

      // Start during SHIFT is ignored
      launch(8'h5A, 8'h23, 1'b0, 1'b0);
      @(negedge clk); @(negedge clk);
      a_r = 8'hFF; start_r = 1'b1;
      @(negedge clk);
      start_r = 1'b0;
      wait_done(4, lat, bc);
      chk("ign.lat", 32'(lat), 32'd9);
      chk("ign.d", 32'(d), 32'h37);
      @(negedge clk);

      // Reset mid-operation discards the op
      launch(8'h5A, 8'h23, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst.busy", 32'(busy), 32'd0);
      chk("midrst.d", 32'(d), 32'd0);
      chk("midrst.done", 32'(done), 32'd0);
      dcount = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) dcount++;
      end
      chk("midrst.no_done", 32'(dcount), 32'd0);
      run_op("post_rst", 8'h80, 8'h01, 1'b0, 1'b0);
      chk("post_rst.lit", 32'(d), 32'h7F);

      // Back-to-back: new start during the DONE cycle
      xa = 8'($urandom); xb = 8'($urandom); xbin = 1'($urandom);
      launch(xa, xb, xbin, 1'b0);
      wait_done(1, lat, bc);
      chk("b2b0.lat", 32'(lat), 32'd9);
      check_res("b2b0", xa, xb, xbin, 1'b0);
      launch(8'h03, 8'h05, 1'b0, 1'b0);
      chk("b2b1.busy_no_gap", 32'(busy), 32'd1);
      wait_done(1, lat, bc);
      chk("b2b1.lat", 32'(lat), 32'd9);
      chk("b2b1.d", 32'(d), 32'hFE);
      chk("b2b1.b_out", 32'(b_out), 32'd1);
      @(negedge clk);

      // Random subtracts, inputs scrambled after acceptance
      for (int i = 0; i < 24; i++) begin
         run_op($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      end

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      run_op("add7F_01", 8'h7F, 8'h01, 1'b0, 1'b1);
      chk("add7F_01.lit", 32'({overflow, b_out, d}), 32'h280);
      for (int i = 0; i < 12; i++) begin
         run_op($sformatf("radd%0d", i), 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
